// File: rtl/light_safety_monitor.sv
// light_safety_monitor: safety stage between traffic_control and the lamp drivers.
// Samples the four light buses, checks encoding, cross-direction conflicts,
// transition legality and phase timing, and forwards legal lights two cycles
// later. Any violation latches a fault code/direction and switches every lamp
// to a flashing all-red pattern until fault_clr.
// Ports:
//   clk, rst_a                 clock, synchronous active-high reset
//   n_in/s_in/e_in/w_in [2:0]  lights from controller (R=100, Y=010, G=001)
//   fault_clr                  single-cycle clear request (ignored in NORMAL)
//   n_out/s_out/e_out/w_out    registered lamp drive
//   fault                      high while faulted
//   fault_code [2:0]           1 enc, 2 conflict, 3 transition, 4 short Y, 5 long G
//   fault_dir  [1:0]           offending direction N=0, S=1, E=2, W=3
//   viol_cnt   [7:0]           faults entered since reset, saturating
module light_safety_monitor #(
  parameter int unsigned MIN_YELLOW = 4,
  parameter int unsigned MAX_GREEN  = 12,
  parameter int unsigned FLASH_HALF = 4
) (
  input  logic       clk,
  input  logic       rst_a,
  input  logic [2:0] n_in,
  input  logic [2:0] s_in,
  input  logic [2:0] e_in,
  input  logic [2:0] w_in,
  input  logic       fault_clr,
  output logic [2:0] n_out,
  output logic [2:0] s_out,
  output logic [2:0] e_out,
  output logic [2:0] w_out,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] fault_dir,
  output logic [7:0] viol_cnt
);

  localparam int unsigned YR_W = $clog2(MIN_YELLOW + 1);
  localparam int unsigned GR_W = $clog2(MAX_GREEN + 1);
  localparam int unsigned FL_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  typedef enum logic [1:0] {ST_NORMAL, ST_FAULT_ON, ST_FAULT_OFF} state_e;

  state_e                     state_q, state_d;
  logic [3:0][2:0]            samp_q;
  logic [3:0][2:0]            prev_q, prev_d;
  logic [3:0][YR_W-1:0]       yrun_q, yrun_d;
  logic [3:0][GR_W-1:0]       grun_q, grun_d;
  logic                       armed_q, armed_d;
  logic [FL_W-1:0]            flash_q, flash_d;
  logic [3:0][2:0]            out_q, out_d;
  logic                       fault_q, fault_d;
  logic [2:0]                 code_q, code_d;
  logic [1:0]                 dir_q, dir_d;
  logic [7:0]                 cnt_q, cnt_d;

  logic [3:0] bad_c, nonred_c, trans_c, shorty_c, longg_c;
  logic [2:0] viol_code_c;
  logic [1:0] viol_dir_c;

  // Lowest set index of a 4-bit direction mask.
  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Per-direction rule checks on the current sample plus history.
  always_comb begin
    bad_c       = '0;
    nonred_c    = '0;
    trans_c     = '0;
    shorty_c    = '0;
    longg_c     = '0;
    viol_code_c = 3'd0;
    viol_dir_c  = 2'd0;
    for (int d = 0; d < 4; d++) begin
      bad_c[d]    = !(samp_q[d] == RED || samp_q[d] == YEL || samp_q[d] == GRN);
      nonred_c[d] = (samp_q[d] != RED);
      trans_c[d]  = armed_q && ((prev_q[d] == GRN && samp_q[d] == RED) ||
                                (prev_q[d] == YEL && samp_q[d] == GRN));
      shorty_c[d] = armed_q && prev_q[d] == YEL && samp_q[d] == RED &&
                    (yrun_q[d] < YR_W'(MIN_YELLOW));
      longg_c[d]  = (samp_q[d] == GRN) && (grun_q[d] == GR_W'(MAX_GREEN));
    end
    if (|bad_c) begin
      viol_code_c = 3'd1;
      viol_dir_c  = lowest_idx(bad_c);
    end else if ((nonred_c & (nonred_c - 4'd1)) != 4'd0) begin
      viol_code_c = 3'd2;
      viol_dir_c  = lowest_idx(nonred_c);
    end else if (|trans_c) begin
      viol_code_c = 3'd3;
      viol_dir_c  = lowest_idx(trans_c);
    end else if (|shorty_c) begin
      viol_code_c = 3'd4;
      viol_dir_c  = lowest_idx(shorty_c);
    end else if (|longg_c) begin
      viol_code_c = 3'd5;
      viol_dir_c  = lowest_idx(longg_c);
    end
  end

  // FSM next state, history update and output pattern.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    yrun_d  = yrun_q;
    grun_d  = grun_q;
    armed_d = armed_q;
    flash_d = flash_q;
    out_d   = out_q;
    fault_d = fault_q;
    code_d  = code_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_NORMAL: begin
        if (viol_code_c != 3'd0) begin
          state_d = ST_FAULT_ON;
          flash_d = '0;
          out_d   = {4{RED}};
          fault_d = 1'b1;
          code_d  = viol_code_c;
          dir_d   = viol_dir_c;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end else begin
          out_d   = samp_q;
          prev_d  = samp_q;
          armed_d = 1'b1;
          for (int d = 0; d < 4; d++) begin
            if (samp_q[d] != YEL) yrun_d[d] = '0;
            else if (yrun_q[d] != YR_W'(MIN_YELLOW)) yrun_d[d] = yrun_q[d] + YR_W'(1);
            if (samp_q[d] != GRN) grun_d[d] = '0;
            else if (grun_q[d] != GR_W'(MAX_GREEN)) grun_d[d] = grun_q[d] + GR_W'(1);
          end
        end
      end
      ST_FAULT_ON, ST_FAULT_OFF: begin
        // Clear wins over anything else; history restarts unarmed.
        if (fault_clr) begin
          state_d = ST_NORMAL;
          fault_d = 1'b0;
          code_d  = 3'd0;
          dir_d   = 2'd0;
          yrun_d  = '0;
          grun_d  = '0;
          armed_d = 1'b0;
          flash_d = '0;
          out_d   = {4{RED}};
        end else if (flash_q == FL_W'(FLASH_HALF - 1)) begin
          flash_d = '0;
          if (state_q == ST_FAULT_ON) begin
            state_d = ST_FAULT_OFF;
            out_d   = {4{OFF}};
          end else begin
            state_d = ST_FAULT_ON;
            out_d   = {4{RED}};
          end
        end else begin
          flash_d = flash_q + FL_W'(1);
        end
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  // State and pipeline registers.
  always_ff @(posedge clk) begin
    if (rst_a) begin
      state_q <= ST_NORMAL;
      samp_q  <= {4{RED}};
      prev_q  <= {4{RED}};
      yrun_q  <= '0;
      grun_q  <= '0;
      armed_q <= 1'b0;
      flash_q <= '0;
      out_q   <= {4{RED}};
      fault_q <= 1'b0;
      code_q  <= 3'd0;
      dir_q   <= 2'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      samp_q  <= {w_in, e_in, s_in, n_in};
      prev_q  <= prev_d;
      yrun_q  <= yrun_d;
      grun_q  <= grun_d;
      armed_q <= armed_d;
      flash_q <= flash_d;
      out_q   <= out_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign n_out      = out_q[0];
  assign s_out      = out_q[1];
  assign e_out      = out_q[2];
  assign w_out      = out_q[3];
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign fault_dir  = dir_q;
  assign viol_cnt   = cnt_q;

endmodule

// File: tb/tb_light_safety_monitor.sv
module tb_light_safety_monitor;

  localparam int MIN_YELLOW = 4;
  localparam int MAX_GREEN  = 12;
  localparam int FLASH_HALF = 4;

  localparam logic [2:0]  RED    = 3'b100;
  localparam logic [2:0]  YEL    = 3'b010;
  localparam logic [2:0]  GRN    = 3'b001;
  localparam logic [11:0] ALLRED = 12'b100_100_100_100;

  logic       clk;
  logic       rst_a;
  logic [2:0] n_in, s_in, e_in, w_in;
  logic       fault_clr;
  logic [2:0] n_out, s_out, e_out, w_out;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] fault_dir;
  logic [7:0] viol_cnt;

  light_safety_monitor #(
    .MIN_YELLOW(MIN_YELLOW),
    .MAX_GREEN (MAX_GREEN),
    .FLASH_HALF(FLASH_HALF)
  ) dut (
    .clk       (clk),
    .rst_a     (rst_a),
    .n_in      (n_in),
    .s_in      (s_in),
    .e_in      (e_in),
    .w_in      (w_in),
    .fault_clr (fault_clr),
    .n_out     (n_out),
    .s_out     (s_out),
    .e_out     (e_out),
    .w_out     (w_out),
    .fault     (fault),
    .fault_code(fault_code),
    .fault_dir (fault_dir),
    .viol_cnt  (viol_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: lights packed {W,E,S,N}, 3 bits each.
  logic [11:0] m_samp;
  logic [11:0] m_hist[$];
  logic [11:0] m_out;
  logic        m_fault;
  int          m_code, m_dir, m_cnt, m_age;
  logic        m_valid = 1'b0;

  typedef struct {
    logic [11:0] pat;
    logic [2:0]  code;
    logic [1:0]  dir;
  } vec_t;
  vec_t tbl[9];

  function automatic logic [11:0] lights(input logic [2:0] n, s, e, w);
    return {w, e, s, n};
  endfunction

  function automatic logic [11:0] one_dir(input int d, input logic [2:0] c);
    logic [11:0] v;
    v = ALLRED;
    v[d*3 +: 3] = c;
    return v;
  endfunction

  // Number of most recent accepted samples in which direction d showed colour c.
  function automatic int trail(input int d, input logic [2:0] c);
    int k;
    logic [11:0] h;
    k = 0;
    for (int i = m_hist.size() - 1; i >= 0; i--) begin
      h = m_hist[i];
      if (h[d*3 +: 3] == c) k++;
      else break;
    end
    return k;
  endfunction

  task automatic evaluate(input logic [11:0] sv, output int code, output int dir);
    logic [2:0]  c, p;
    logic [11:0] prev;
    int          nonred;
    bit          armed;
    armed  = (m_hist.size() > 0);
    prev   = armed ? m_hist[m_hist.size()-1] : ALLRED;
    code   = 0;
    dir    = 0;
    nonred = 0;
    for (int d = 3; d >= 0; d--) begin
      c = sv[d*3 +: 3];
      if (c != RED && c != YEL && c != GRN) begin code = 1; dir = d; end
    end
    if (code != 0) return;
    for (int d = 3; d >= 0; d--) begin
      if (sv[d*3 +: 3] != RED) begin nonred++; dir = d; end
    end
    if (nonred > 1) begin code = 2; return; end
    dir = 0;
    for (int r = 3; r <= 5 && code == 0; r++) begin
      for (int d = 3; d >= 0; d--) begin
        c = sv[d*3 +: 3];
        p = prev[d*3 +: 3];
        if ((r == 3 && armed && ((p == GRN && c == RED) || (p == YEL && c == GRN))) ||
            (r == 4 && armed && p == YEL && c == RED && trail(d, YEL) < MIN_YELLOW) ||
            (r == 5 && c == GRN && trail(d, GRN) >= MAX_GREEN)) begin
          code = r;
          dir  = d;
        end
      end
    end
  endtask

  task automatic model_edge(input logic [11:0] in_v, input logic clr, input logic rst);
    int code, dir;
    if (rst) begin
      m_samp  = ALLRED;
      m_hist.delete();
      m_out   = ALLRED;
      m_fault = 1'b0;
      m_code  = 0;
      m_dir   = 0;
      m_cnt   = 0;
      m_age   = 0;
      m_valid = 1'b1;
      return;
    end
    if (!m_fault) begin
      evaluate(m_samp, code, dir);
      if (code != 0) begin
        m_fault = 1'b1;
        m_age   = 0;
        m_code  = code;
        m_dir   = dir;
        m_cnt   = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_out   = ALLRED;
      end else begin
        m_out = m_samp;
        m_hist.push_back(m_samp);
        if (m_hist.size() > 20) void'(m_hist.pop_front());
      end
    end else if (clr) begin
      m_fault = 1'b0;
      m_code  = 0;
      m_dir   = 0;
      m_hist.delete();
      m_out   = ALLRED;
    end else begin
      m_age++;
      m_out = (((m_age / FLASH_HALF) % 2) == 0) ? ALLRED : 12'd0;
    end
    m_samp = in_v;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] dut_lights();
    return {w_out, e_out, s_out, n_out};
  endfunction

  // One clock: drive at negedge, model the edge, compare #1 after it.
  task automatic step(input logic [11:0] v, input logic c = 1'b0, input logic r = 1'b0);
    @(negedge clk);
    n_in = v[2:0]; s_in = v[5:3]; e_in = v[8:6]; w_in = v[11:9];
    fault_clr = c;
    rst_a = r;
    @(posedge clk);
    model_edge(v, c, r);
    #1;
    if (m_valid)
      chk("model", {6'd0, dut_lights(), fault, fault_code, fault_dir, viol_cnt},
          {6'd0, m_out, m_fault, 3'(m_code), 2'(m_dir), 8'(m_cnt)});
  endtask

  task automatic do_reset();
    step(ALLRED, 1'b0, 1'b1);
    step(ALLRED);
    step(ALLRED);
  endtask

  // G8/Y4 per direction in order N,S,E,W; outputs must be the previous step's inputs.
  task automatic nominal(input int cycles);
    logic [11:0] prev_in, v;
    int p;
    prev_in = ALLRED;
    for (int k = 0; k < cycles; k++) begin
      p = k % 48;
      v = one_dir(p / 12, ((p % 12) < 8) ? GRN : YEL);
      step(v);
      chk("nominal_delay", {20'd0, dut_lights()}, {20'd0, prev_in});
      chk("nominal_nofault", {31'd0, fault}, 32'd0);
      prev_in = v;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_in = RED; s_in = RED; e_in = RED; w_in = RED;
    fault_clr = 1'b0;
    rst_a = 1'b1;

    tbl[0] = '{lights(3'b011, RED, RED, RED),    3'd1, 2'd0};
    tbl[1] = '{lights(GRN, RED, GRN, RED),       3'd2, 2'd0};
    tbl[2] = '{lights(RED, YEL, RED, GRN),       3'd2, 2'd1};
    tbl[3] = '{lights(RED, RED, RED, 3'b000),    3'd1, 2'd3};
    tbl[4] = '{lights(RED, GRN, RED, RED),       3'd3, 2'd1};
    tbl[5] = '{lights(RED, RED, RED, YEL),       3'd4, 2'd3};
    tbl[6] = '{lights(GRN, 3'b110, RED, RED),    3'd1, 2'd1};
    tbl[7] = '{lights(RED, RED, RED, RED),       3'd0, 2'd0};
    tbl[8] = '{lights(RED, RED, YEL, YEL),       3'd2, 2'd2};

    // Reset state.
    step(ALLRED, 1'b0, 1'b1);
    chk("reset_lights", {20'd0, dut_lights()}, {20'd0, ALLRED});
    chk("reset_status", {18'd0, fault, fault_code, fault_dir, viol_cnt}, 32'd0);
    step(ALLRED);
    step(ALLRED);

    // Nominal traffic.
    nominal(300);

    // Single-cycle pattern table: one pattern then all-red.
    foreach (tbl[i]) begin
      do_reset();
      step(tbl[i].pat);
      step(ALLRED);
      step(ALLRED);
      step(ALLRED);
      chk($sformatf("tbl%0d_fault", i), {31'd0, fault}, {31'd0, (tbl[i].code != 3'd0)});
      chk($sformatf("tbl%0d_code", i), {29'd0, fault_code}, {29'd0, tbl[i].code});
      chk($sformatf("tbl%0d_dir", i), {30'd0, fault_dir}, {30'd0, tbl[i].dir});
    end

    // Conflict then flash pattern, clear during the off half.
    do_reset();
    step(lights(GRN, RED, GRN, RED));
    step(ALLRED);
    chk("conflict_fault", {26'd0, fault, fault_code, fault_dir}, {26'd0, 1'b1, 3'd2, 2'd0});
    chk("conflict_red", {20'd0, dut_lights()}, {20'd0, ALLRED});
    for (int k = 1; k <= 11; k++) begin
      step(one_dir(0, GRN));
      chk($sformatf("flash_%0d", k), {20'd0, dut_lights()},
          {20'd0, (((k / 4) % 2) == 0) ? ALLRED : 12'd0});
    end
    for (int k = 12; k <= 13; k++) step(ALLRED);
    chk("flash_off_before_clr", {20'd0, dut_lights()}, 32'd0);
    step(ALLRED, 1'b1);
    chk("clear_status", {26'd0, fault, fault_code, fault_dir}, 32'd0);
    nominal(96);
    chk("after_clear_code", {29'd0, fault_code}, 32'd0);

    // Short yellow on west.
    do_reset();
    step(one_dir(3, YEL));
    step(one_dir(3, YEL));
    step(ALLRED);
    step(ALLRED);
    chk("short_yellow", {27'd0, fault_code, fault_dir}, {27'd0, 3'd4, 2'd3});

    // Long green on east: 13th sample trips.
    do_reset();
    for (int k = 0; k < 13; k++) step(one_dir(2, GRN));
    chk("green12_ok", {31'd0, fault}, 32'd0);
    step(ALLRED);
    chk("long_green", {26'd0, fault, fault_code, fault_dir}, {26'd0, 1'b1, 3'd5, 2'd2});

    // Saturating violation counter.
    do_reset();
    for (int k = 0; k < 260; k++) begin
      step(lights(3'b011, RED, RED, RED));
      step(ALLRED);
      step(ALLRED, 1'b1);
      if (k == 254) chk("viol_cnt_255", {24'd0, viol_cnt}, 32'd255);
    end
    chk("viol_cnt_sat", {24'd0, viol_cnt}, 32'd255);

    // Reset while flashing.
    step(one_dir(1, 3'b111));
    step(ALLRED);
    for (int k = 0; k < 5; k++) step(ALLRED);
    step(ALLRED, 1'b0, 1'b1);
    chk("midflash_reset_lights", {20'd0, dut_lights()}, {20'd0, ALLRED});
    chk("midflash_reset_status", {18'd0, fault, fault_code, fault_dir, viol_cnt}, 32'd0);
    step(ALLRED);
    step(ALLRED);

    // Randomised traffic with glitches, clears and occasional reset.
    for (int seg = 0; seg < 80; seg++) begin
      int d, gl, yl;
      d  = $urandom_range(0, 3);
      gl = $urandom_range(1, 14);
      yl = $urandom_range(1, 6);
      for (int k = 0; k < gl + yl; k++) begin
        logic [11:0] v;
        v = one_dir(d, (k < gl) ? GRN : YEL);
        if ($urandom_range(0, 19) == 0) v = 12'($urandom());
        step(v, ($urandom_range(0, 9) == 0), ($urandom_range(0, 299) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
